// File: rtl/reset_sequencer.sv
// Releases N_OUT active-low reset domains DLY_STEP cycles apart, plus a one-cycle init pulse.
// Outputs registered from next-state (1 cycle); button latency 2+DEB_CYC cycles; no backpressure.
module reset_sequencer #(
  parameter int N_OUT    = 3,
  parameter int DLY_STEP = 100,
  parameter int PULSE_AT = 200,
  parameter int DEB_CYC  = 16
) (
  input  logic             sysclk,
  input  logic             reset1,
  input  logic             btn_rst_n,
  input  logic             soft_rst_req,
  output logic [N_OUT-1:0] rst_n_out,
  output logic             init_pulse_n,
  output logic             busy,
  output logic             seq_done
);

  localparam int SEQ_LEN = N_OUT * DLY_STEP;
  localparam int CNT_W   = $clog2(SEQ_LEN + 1);
  localparam int DEB_W   = $clog2(DEB_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_AT);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYC - 1);

  if (PULSE_AT < 1 || PULSE_AT > SEQ_LEN) begin : g_bad_pulse_at
    $error("reset_sequencer: PULSE_AT must lie in 1..N_OUT*DLY_STEP");
  end

  typedef enum logic [1:0] {
    RAMP = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic             btn_s1;
  logic             btn_s2;
  logic             btn_db;
  logic [DEB_W-1:0] deb_cnt;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_hit;
  logic [N_OUT-1:0] rst_nxt;
  logic             seq_done_nxt;

  // Debounced level only follows after DEB_CYC consecutive disagreeing samples.
  always_ff @(posedge sysclk or negedge reset1) begin
    if (!reset1) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_db  <= 1'b1;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= btn_rst_n;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // The pulse is tied to the ramp step that lands on PULSE_AT, so it also fires
  // when PULSE_AT equals the final count (the same step that enters RUN).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_hit = 1'b0;
    case (state)
      RAMP, RUN: begin
        if (!btn_db) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (soft_rst_req) begin
          state_nxt = RAMP;
          cnt_nxt   = '0;
        end else if (state == RAMP) begin
          cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          state_nxt = (cnt_nxt == CNT_MAX) ? RUN : RAMP;
          pulse_hit = (cnt_nxt == PULSE_CNT);
        end
      end
      HOLD: begin
        cnt_nxt = '0;
        if (btn_db) state_nxt = RAMP;
      end
      default: begin
        state_nxt = RAMP;
        cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_release
    localparam logic [CNT_W-1:0] THR = CNT_W'((i + 1) * DLY_STEP);
    assign rst_nxt[i] = (state_nxt != HOLD) && (cnt_nxt >= THR);
  end

  assign seq_done_nxt = (state_nxt == RUN);

  always_ff @(posedge sysclk or negedge reset1) begin
    if (!reset1) begin
      state        <= RAMP;
      cnt          <= '0;
      rst_n_out    <= '0;
      init_pulse_n <= 1'b1;
      busy         <= 1'b1;
      seq_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rst_n_out    <= rst_nxt;
      init_pulse_n <= !pulse_hit;
      busy         <= !seq_done_nxt;
      seq_done     <= seq_done_nxt;
    end
  end

endmodule
